oam_dma_ctrl: RTL and testbench
===============================

# oam_dma_ctrl

Sprite-DMA controller that shares the single memory bus between the `cpu6502` core and a 256-byte block copier. When the CPU writes page number `$PP` to `DMA_REG`, the block stalls the CPU through `cpu_rdy`. It then takes the bus and copies `$PP00–$PPFF` to `DEST_ADDR` as alternating read/write cycles, and returns the bus to the CPU. It sits between the CPU bus pins and the ROM/RAM/PPU decode.

## Interface
Parameters:
- `DMA_REG`, `16'h4014`: trigger register address (write-only).
- `DEST_ADDR`, `16'h2004`: fixed write destination for every copied byte.
- `LEN`, `256`: bytes per transfer; must be a power of two, ≤ 256.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high.
- `cyc_en`  in  1: one-`clk` pulse marking the end of each CPU bus cycle (falling edge of `clk2`). All state advances only on `cyc_en`.
- `cpu_addr`  in  16: CPU address.
- `cpu_odata`  in  8: CPU write data.
- `cpu_rw`  in  1: CPU direction; 1 = read.
- `mem_idata`  in  8: bus read data, valid when `cyc_en` is high.
- `addr`  out  16: muxed bus address.
- `odata`  out  8: muxed write data.
- `rw`  out  1: muxed direction.
- `cpu_rdy`  out  1: 0 stalls the CPU on its next read cycle.
- `busy`  out  1: high from the trigger until the final write completes.

## Operation
- States: `IDLE`, `HALT`, `ALIGN`, `READ`, `WRITE`.
- `IDLE`: bus outputs = CPU signals. On `cyc_en` with `cpu_rw==0 && cpu_addr==DMA_REG`: latch `page<=cpu_odata`, `idx<=0`, go to `HALT`.
- `HALT`: `cpu_rdy=0`; bus passes the CPU signals. On a `cyc_en` where `cpu_rw==1` (CPU frozen on a read):
  - `parity==0`: go to `READ`.
  - `parity==1`: go to `ALIGN`.
  - CPU write cycles (up to 3, e.g. RMW) complete normally while in `HALT`.
- `ALIGN`: one dummy cycle; bus passes the CPU (repeated read). On `cyc_en` go to `READ`.
- `READ`: `addr={page, idx[7:0]}`, `rw=1`. On `cyc_en`: `data<=mem_idata`, go to `WRITE`.
- `WRITE`: `addr=DEST_ADDR`, `odata=data`, `rw=0`. On `cyc_en`:
  - `idx==LEN-1`: go to `IDLE`.
  - otherwise `idx<=idx+1`, go to `READ`.
- `parity` toggles on every `cyc_en` regardless of state, so `READ` always starts on an even cycle.
- Address arithmetic: `idx` is 8 bits. Reading `$PPFF` never carries into the page byte.
- A write to `DMA_REG` while `busy` is ignored; the CPU is stalled, so none occurs in practice.

## Timing
- Reset values: state `IDLE`, `cpu_rdy=1`, `busy=0`, `parity=0`, `idx=0`, `page=0`, `data=0`. Bus outputs equal the CPU inputs.
- Bus outputs are combinational from the state register and CPU inputs. `cpu_rdy` and `busy` are registered.
- `cpu_rdy` goes to 0 on the `clk` edge after the trigger `cyc_en`. It returns to 1 on the `clk` edge after the final `WRITE` `cyc_en`.
- Transfer length, trigger to release: 1 + n_w + (0|1) + 2·LEN bus cycles.
  - n_w = CPU write cycles spent in `HALT`.
  - Typical (n_w=0): 513 or 514 cycles.
- Reset mid-transfer aborts immediately. Outputs return to the reset values asynchronously, and the CPU resumes on deassertion. The partially copied bytes remain in memory.
- `cyc_en` held low freezes all state, including `parity`.

## Structure
- Shared package `dma_pkg`: state enum, and `DMA_REG`/`DEST_ADDR` defaults reused by the address decoder.
- Single module; no sub-module is warranted. The output mux and the FSM live together.

## Test plan
- `STA $4014` with A=`$02`, RAM `$0200–$02FF` = index pattern → 256 writes to `$2004` with data `$00..$FF` in order. CPU resumes at the next opcode. `busy` stays high for 513 cycles.
- Same trigger issued on an odd cycle → exactly one `ALIGN` cycle. The first `READ` address is `$0200`; total cycles = 514.
- Page `$FF` → last read at `$FFFF`, not `$0000`. The final write carries `mem[$FFFF]`.
- `reset` asserted after 100 copied bytes → `cpu_rdy=1` and `busy=0` immediately. A subsequent `STA $4014` starts a fresh copy from `idx=0`.
- `cyc_en` held low 10 clocks mid-`READ` → address stable throughout; no extra writes; byte count still 256.
- CPU write to `$4015` or a read of `$4014` → no trigger; `busy` stays 0.

Source files
------------

// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_pkg
// Description : Shared state encoding and bus-address defaults for sprite DMA.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } dma_state_t;

   localparam logic [15:0] c_dma_reg   = 16'h4014;
   localparam logic [15:0] c_dest_addr = 16'h2004;

endpackage
`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_ctrl
// Description : Stalls the CPU and copies one page to a fixed port as
//               alternating read/write bus cycles, then hands the bus back.
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_ctrl
   import dma_pkg::*;
#(
   parameter logic [15:0] DMA_REG   = c_dma_reg,
   parameter logic [15:0] DEST_ADDR = c_dest_addr,
   parameter int          LEN       = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cyc_en,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_odata,
   input  logic        cpu_rw,
   input  logic [7:0]  mem_idata,
   output logic [15:0] addr,
   output logic [7:0]  odata,
   output logic        rw,
   output logic        cpu_rdy,
   output logic        busy
);

   localparam logic [7:0] c_last_idx = 8'(LEN - 1);

   dma_state_t r_state;
   logic [7:0] r_page;
   logic [7:0] r_idx;
   logic [7:0] r_data;
   logic       r_parity;
   logic       r_cpu_rdy;
   logic       r_busy;
   logic       w_trigger;

   assign w_trigger = !cpu_rw && (cpu_addr == DMA_REG);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_page    <= 8'h00;
         r_idx     <= 8'h00;
         r_data    <= 8'h00;
         r_parity  <= 1'b0;
         r_cpu_rdy <= 1'b1;
         r_busy    <= 1'b0;
      end else if (cyc_en) begin
         r_parity <= !r_parity;
         case (r_state)
            IDLE: begin
               if (w_trigger) begin
                  r_page    <= cpu_odata;
                  r_idx     <= 8'h00;
                  r_cpu_rdy <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= HALT;
               end
            end
            // Wait for the CPU to park on a read; writes (e.g. RMW) finish first.
            HALT: begin
               if (cpu_rw) begin
                  r_state <= r_parity ? ALIGN : READ;
               end
            end
            ALIGN: begin
               r_state <= READ;
            end
            READ: begin
               r_data  <= mem_idata;
               r_state <= WRITE;
            end
            WRITE: begin
               if (r_idx == c_last_idx) begin
                  r_cpu_rdy <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= IDLE;
               end else begin
                  r_idx   <= r_idx + 8'd1;
                  r_state <= READ;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Idle, halt and align cycles leave the CPU driving the bus untouched.
   always_comb begin
      addr  = cpu_addr;
      odata = cpu_odata;
      rw    = cpu_rw;
      case (r_state)
         READ: begin
            addr = {r_page, r_idx};
            rw   = 1'b1;
         end
         WRITE: begin
            addr  = DEST_ADDR;
            odata = r_data;
            rw    = 1'b0;
         end
         default: begin
         end
      endcase
   end

   assign cpu_rdy = r_cpu_rdy;
   assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_oam_dma_ctrl
// Description : Scoreboard bench: stimulus queues expected reads/writes, a
//               bus monitor pops and compares on every bus cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_dma_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cyc_en;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_odata;
   logic        cpu_rw;
   logic [7:0]  mem_idata;
   logic [15:0] addr;
   logic [7:0]  odata;
   logic        rw;
   logic        cpu_rdy;
   logic        busy;

   logic [7:0]  mem [0:65535];
   logic [15:0] rq[$];
   logic [7:0]  wq[$];

   int checks      = 0;
   int failures    = 0;
   int busy_cycles = 0;
   int dma_writes  = 0;
   int ncyc        = 0;

   always #5 clk = ~clk;

   assign mem_idata = mem[addr];

   oam_dma_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .cyc_en    (cyc_en),
      .cpu_addr  (cpu_addr),
      .cpu_odata (cpu_odata),
      .cpu_rw    (cpu_rw),
      .mem_idata (mem_idata),
      .addr      (addr),
      .odata     (odata),
      .rw        (rw),
      .cpu_rdy   (cpu_rdy),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One bus cycle: inputs set at a falling edge, cyc_en seen by the next rising edge.
   task automatic cycle(input logic [15:0] a, input logic r, input logic [7:0] d);
      cpu_addr  = a;
      cpu_rw    = r;
      cpu_odata = d;
      cyc_en    = 1'b1;
      @(negedge clk);
      cyc_en    = 1'b0;
      @(negedge clk);
      ncyc++;
   endtask

   // Trigger parity: odd ncyc gives no ALIGN cycle, even ncyc gives one.
   task automatic set_parity(input bit want_odd);
      if ((ncyc % 2 == 1) != want_odd) cycle(16'h8000, 1'b1, 8'h00);
   endtask

   task automatic load_expect(input logic [7:0] pg);
      for (int i = 0; i < 256; i++) begin
         rq.push_back({pg, 8'(i)});
         wq.push_back(mem[{pg, 8'(i)}]);
      end
   endtask

   task automatic run_xfer(input logic [7:0] pg, input int exp_cyc, input bit do_freeze);
      int          n;
      bit          froze;
      bit          stable;
      logic [15:0] a0;
      froze = 1'b0;
      load_expect(pg);
      busy_cycles = 0;
      dma_writes  = 0;
      cycle(16'h4014, 1'b0, pg);
      chk("rdy_low_after_trigger", 32'(cpu_rdy), 32'd0);
      chk("busy_after_trigger", 32'(busy), 32'd1);
      n = 0;
      while (!cpu_rdy && n < 700) begin
         if (do_freeze && !froze && dma_writes == 50 && rw && addr != cpu_addr) begin
            a0     = addr;
            stable = 1'b1;
            repeat (10) begin
               @(negedge clk);
               if (addr !== a0) stable = 1'b0;
            end
            chk("freeze_addr_stable", 32'(stable), 32'd1);
            chk("freeze_no_writes", 32'(dma_writes), 32'd50);
            froze = 1'b1;
         end
         cycle(16'h8003, 1'b1, 8'h00);
         n++;
      end
      if (n >= 700) begin
         checks++;
         failures++;
         $display("FAIL xfer_timeout: cpu_rdy still %0d after %0d cycles", cpu_rdy, n);
      end
      if (do_freeze) chk("freeze_happened", 32'(froze), 32'd1);
      chk("busy_cycles", 32'(busy_cycles), 32'(exp_cyc));
      chk("write_count", 32'(dma_writes), 32'd256);
      chk("reads_left", 32'(rq.size()), 32'd0);
      chk("writes_left", 32'(wq.size()), 32'd0);
      chk("busy_released", 32'(busy), 32'd0);
      chk("cpu_resume_addr", 32'(addr), 32'h8003);
      rq.delete();
      wq.delete();
   endtask

   // Bus monitor, sampled midway through the cyc_en clock.
   always @(negedge clk) begin
      #1;
      if (cyc_en && !reset) begin
         if (busy) busy_cycles++;
         if (!rw && addr == 16'h2004) begin
            dma_writes++;
            if (wq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL extra_write: data %0h with no expected write", odata);
            end else begin
               chk("write_data", 32'(odata), 32'(wq.pop_front()));
            end
         end else if (rw && !cpu_rdy && addr != cpu_addr) begin
            if (rq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL extra_read: addr %0h with no expected read", addr);
            end else begin
               chk("read_addr", 32'(addr), 32'(rq.pop_front()));
            end
         end
      end
   end

   initial begin
      int n;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      for (int i = 0; i < 256; i++) begin
         mem[16'h0200 + i] = 8'(i);
         mem[16'h0300 + i] = 8'(255 - i);
         mem[16'hFF00 + i] = 8'(i) ^ 8'h5A;
      end
      mem[16'h0000] = 8'hEE;

      reset     = 1'b1;
      cyc_en    = 1'b0;
      cpu_addr  = 16'h1234;
      cpu_odata = 8'hA5;
      cpu_rw    = 1'b1;
      @(negedge clk);
      chk("reset_rdy", 32'(cpu_rdy), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_addr_pass", 32'(addr), 32'h1234);
      chk("reset_odata_pass", 32'(odata), 32'hA5);
      chk("reset_rw_pass", 32'(rw), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      ncyc  = 0;

      // Non-trigger accesses.
      cycle(16'h4015, 1'b0, 8'h02);
      chk("wr4015_busy", 32'(busy), 32'd0);
      cycle(16'h4014, 1'b1, 8'h02);
      chk("rd4014_busy", 32'(busy), 32'd0);
      chk("rd4014_rdy", 32'(cpu_rdy), 32'd1);

      set_parity(1'b1);
      run_xfer(8'h02, 513, 1'b0);

      set_parity(1'b0);
      run_xfer(8'h02, 514, 1'b0);

      set_parity(1'b1);
      run_xfer(8'hFF, 513, 1'b0);

      // Abort after 100 bytes.
      load_expect(8'h03);
      dma_writes = 0;
      cycle(16'h4014, 1'b0, 8'h03);
      n = 0;
      while (dma_writes < 100 && n < 400) begin
         cycle(16'h8003, 1'b1, 8'h00);
         n++;
      end
      chk("abort_reached_100", 32'(dma_writes), 32'd100);
      reset = 1'b1;
      #1;
      chk("abort_rdy", 32'(cpu_rdy), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      rq.delete();
      wq.delete();
      @(negedge clk);
      reset = 1'b0;
      ncyc  = 0;

      set_parity(1'b1);
      run_xfer(8'h03, 513, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
